// File: rtl/dmem_bridge_wires.sv
`default_nettype none
// ============================================================================
//  Package : dmem_bridge_wires
//  Purpose : State/kind encodings and the register record for dmem_bridge.
//  Rev     : 1.0  initial release
// ============================================================================
package dmem_bridge_wires;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        DRAIN = 3'd2,
        RESP  = 3'd3,
        ACK   = 3'd4
    } bridge_state_type;

    typedef enum logic [1:0] {
        STORE = 2'd0,
        LOAD  = 2'd1,
        FENCE = 2'd2
    } kind_type;

    typedef struct packed {
        bridge_state_type state;
        kind_type         kind;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic [3:0]       wstrb;
        logic             req_valid;
        logic             mem_ready;
        logic [31:0]      rdata;
        logic             err;
    } reg_type;

    localparam reg_type INIT_REG = '{
        state:     IDLE,
        kind:      STORE,
        addr:      32'd0,
        wdata:     32'd0,
        wstrb:     4'd0,
        req_valid: 1'b0,
        mem_ready: 1'b0,
        rdata:     32'd0,
        err:       1'b0
    };

endpackage
`default_nettype wire

// File: rtl/wires.sv
`default_nettype none
// ============================================================================
//  Package : wires
//  Purpose : Shared request/response records for the upstream data-memory
//            interface (store buffer side of the bridge).
//            mem_in_type  : mem_valid pulse, mem_instr, mem_fence, addr, wdata, wstrb
//            mem_out_type : mem_ready pulse, mem_rdata
//  Rev     : 1.0  initial release
// ============================================================================
package wires;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic        mem_fence;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

endpackage
`default_nettype wire

// File: rtl/dmem_bridge_credit.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_bridge_credit
//  Purpose : Saturating up/down counter of posted writes awaiting a response.
//  Ports   : clk, rst_n (async active-low)
//            i_inc  - one write accepted by the bus
//            i_dec  - one write response returned
//            o_full - count == MAX_OUT
//            o_zero - count == 0
//  Rev     : 1.0  initial release
// ============================================================================
module dmem_bridge_credit #(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_zero
);

    logic [CNT_W-1:0] r_count;

    assign o_full = (r_count == CNT_W'(MAX_OUT));
    assign o_zero = (r_count == '0);

    // Simultaneous inc+dec leaves the count unchanged; guards stop wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({i_inc, i_dec})
                2'b10:   if (!o_full) r_count <= r_count + 1'b1;
                2'b01:   if (!o_zero) r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_bridge
//  Purpose : Converts the store-buffer mem_valid/mem_ready pulse protocol into
//            a valid/ready bus request channel plus in-order response channel.
//            Stores are posted (up to MAX_OUT awaiting response); loads and
//            fences drain outstanding writes first.
//  Ports   : clock, reset (async active-low)
//            dmem_in / dmem_out           upstream request / ack+rdata
//            bus_req_valid/ready/write/addr/wdata/wstrb   request channel
//            bus_rsp_valid/rdata          response channel
//            err                          sticky stray-response flag
//  Rev     : 1.0  initial release
// ============================================================================
module dmem_bridge
    import wires::*;
    import dmem_bridge_wires::*;
#(
    parameter int MAX_OUT = 4,
    localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_write,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    output logic        err
);

    reg_type r_reg;

    logic w_inc;
    logic w_dec;
    logic w_full;
    logic w_zero;
    logic w_room_next;
    logic w_unused;

    assign w_unused = dmem_in.mem_instr;

    assign w_inc = (r_reg.state == REQ) && r_reg.req_valid && bus_req_ready
                   && (r_reg.kind == STORE);
    // In RESP the counter is already zero, so the response belongs to the load.
    assign w_dec = bus_rsp_valid && !w_zero && (r_reg.state != RESP);

    // Credit available next cycle; a response arriving now frees a slot that
    // the request register may claim at the same edge.
    assign w_room_next = w_dec || !w_full;

    dmem_bridge_credit #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_credit (
        .clk    (clock),
        .rst_n  (reset),
        .i_inc  (w_inc),
        .i_dec  (w_dec),
        .o_full (w_full),
        .o_zero (w_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_reg <= INIT_REG;
        end else begin
            if (bus_rsp_valid && w_zero && (r_reg.state != RESP))
                r_reg.err <= 1'b1;

            case (r_reg.state)
                IDLE: begin
                    if (dmem_in.mem_valid) begin
                        r_reg.addr  <= dmem_in.mem_addr;
                        r_reg.wdata <= dmem_in.mem_wdata;
                        r_reg.wstrb <= dmem_in.mem_wstrb;
                        if (dmem_in.mem_fence) begin
                            r_reg.kind  <= FENCE;
                            r_reg.state <= DRAIN;
                        end else if (dmem_in.mem_wstrb != 4'd0) begin
                            r_reg.kind      <= STORE;
                            r_reg.state     <= REQ;
                            r_reg.req_valid <= w_room_next;
                        end else begin
                            r_reg.kind  <= LOAD;
                            r_reg.state <= DRAIN;
                        end
                    end
                end
                REQ: begin
                    if (r_reg.req_valid && bus_req_ready) begin
                        r_reg.req_valid <= 1'b0;
                        if (r_reg.kind == STORE) begin
                            r_reg.mem_ready <= 1'b1;
                            r_reg.state     <= ACK;
                        end else begin
                            r_reg.state <= RESP;
                        end
                    end else if (r_reg.kind == STORE) begin
                        r_reg.req_valid <= w_room_next;
                    end
                end
                DRAIN: begin
                    if (w_zero) begin
                        if (r_reg.kind == FENCE) begin
                            r_reg.mem_ready <= 1'b1;
                            r_reg.state     <= ACK;
                        end else begin
                            r_reg.req_valid <= 1'b1;
                            r_reg.state     <= REQ;
                        end
                    end
                end
                RESP: begin
                    if (bus_rsp_valid) begin
                        r_reg.rdata     <= bus_rsp_rdata;
                        r_reg.mem_ready <= 1'b1;
                        r_reg.state     <= ACK;
                    end
                end
                ACK: begin
                    r_reg.mem_ready <= 1'b0;
                    r_reg.rdata     <= 32'd0;
                    r_reg.state     <= IDLE;
                end
                default: r_reg.state <= IDLE;
            endcase
        end
    end

    assign dmem_out.mem_ready = r_reg.mem_ready;
    assign dmem_out.mem_rdata = r_reg.rdata;
    assign bus_req_valid      = r_reg.req_valid;
    assign bus_req_write      = (r_reg.kind == STORE) && (r_reg.state != IDLE);
    assign bus_req_addr       = r_reg.addr;
    assign bus_req_wdata      = r_reg.wdata;
    assign bus_req_wstrb      = r_reg.wstrb;
    assign err                = r_reg.err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dmem_bridge
//  Purpose : Directed, scoreboard-checked bench for dmem_bridge (MAX_OUT=4).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_dmem_bridge;
    import wires::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    mem_in_type  dmem_in;
    mem_out_type dmem_out;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_write;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        err;

    dmem_bridge #(.MAX_OUT(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .dmem_in       (dmem_in),
        .dmem_out      (dmem_out),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_write (bus_req_write),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wdata (bus_req_wdata),
        .bus_req_wstrb (bus_req_wstrb),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_rdata (bus_rsp_rdata),
        .err           (err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_ack[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_hs  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a handshake or ack.
    always @(negedge clock) begin
        if (reset) begin
            if (bus_req_valid && bus_req_ready) begin
                n_hs++;
                if (exp_req.size() == 0) begin
                    chk("unexpected_bus_req", 64'd1, 64'd0);
                end else begin
                    req_t e;
                    e = exp_req.pop_front();
                    chk("bus_req_fields",
                        {bus_req_write, bus_req_addr, bus_req_wstrb, (bus_req_write ? bus_req_wdata[25:0] : 26'd0)},
                        {e.write, e.addr, e.wstrb, (e.write ? e.wdata[25:0] : 26'd0)});
                    if (e.write) chk("bus_req_wdata", {32'd0, bus_req_wdata}, {32'd0, e.wdata});
                end
            end
            if (dmem_out.mem_ready) begin
                if (exp_ack.size() == 0) begin
                    chk("unexpected_mem_ready", 64'd1, 64'd0);
                end else begin
                    logic [31:0] a;
                    a = exp_ack.pop_front();
                    chk("mem_rdata", {32'd0, dmem_out.mem_rdata}, {32'd0, a});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents a one-cycle mem_valid pulse and records what should follow.
    task automatic issue(input logic fence, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] rdata);
        req_t r;
        dmem_in           = '0;
        dmem_in.mem_valid = 1'b1;
        dmem_in.mem_fence = fence;
        dmem_in.mem_addr  = addr;
        dmem_in.mem_wdata = wdata;
        dmem_in.mem_wstrb = wstrb;
        if (!fence) begin
            r.write = (wstrb != 4'd0);
            r.addr  = addr;
            r.wdata = wdata;
            r.wstrb = wstrb;
            exp_req.push_back(r);
        end
        exp_ack.push_back((fence || wstrb != 4'd0) ? 32'd0 : rdata);
        tick();
        dmem_in = '0;
    endtask

    task automatic rsp(input logic [31:0] rdata);
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = rdata;
        tick();
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = 32'd0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!dmem_out.mem_ready && n < 20) begin
            tick();
            n++;
        end
        chk(name, {63'd0, dmem_out.mem_ready}, 64'd1);
        tick();
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!bus_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk(name, {63'd0, bus_req_valid}, 64'd1);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] wdata);
        issue(1'b0, addr, wdata, 4'hF, 32'd0);
        wait_ready("store_ack");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        dmem_in       = '0;
        bus_req_ready = 1'b1;
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = 32'd0;
        tick();
        tick();
        // Reset state
        chk("rst_req_valid", {63'd0, bus_req_valid}, 64'd0);
        chk("rst_dmem_out",  {31'd0, dmem_out},      64'd0);
        chk("rst_err",       {63'd0, err},           64'd0);
        chk("rst_req_addr",  {32'd0, bus_req_addr},  64'd0);
        reset = 1'b1;
        tick();

        // 1: single store latency and counter
        issue(1'b0, 32'h100, 32'hDEADBEEF, 4'hF, 32'd0);
        chk("t1_valid_c1", {62'd0, bus_req_valid, bus_req_write}, 64'd3);
        tick();
        chk("t1_ready_c2", {63'd0, dmem_out.mem_ready}, 64'd1);
        tick();
        chk("t1_count1", {61'd0, dut.u_credit.r_count}, 64'd1);
        rsp(32'd0);
        chk("t1_count0", {61'd0, dut.u_credit.r_count}, 64'd0);

        // 2: credit exhaustion
        for (int i = 0; i < 4; i++) do_store(32'h1000 + 32'(i * 4), 32'hA000 + 32'(i));
        issue(1'b0, 32'h1010, 32'hA004, 4'hF, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_invalid", {63'd0, bus_req_valid}, 64'd0);
            tick();
        end
        rsp(32'd0);
        chk("t2_issue_after_rsp", {63'd0, bus_req_valid}, 64'd1);
        tick();
        chk("t2_count_full", {61'd0, dut.u_credit.r_count}, 64'd4);
        wait_ready("t2_ack5");
        for (int i = 0; i < 4; i++) rsp(32'd0);
        chk("t2_drained", {61'd0, dut.u_credit.r_count}, 64'd0);

        // 3: load behind two posted stores
        do_store(32'h180, 32'h11111111);
        do_store(32'h184, 32'h22222222);
        issue(1'b0, 32'h200, 32'h0, 4'h0, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            chk("t3_no_read", {63'd0, bus_req_valid}, 64'd0);
            tick();
        end
        rsp(32'd0);
        rsp(32'd0);
        wait_req("t3_read_issued");
        tick();
        rsp(32'h12345678);
        chk("t3_ready", {63'd0, dmem_out.mem_ready}, 64'd1);
        chk("t3_rdata", {32'd0, dmem_out.mem_rdata}, 64'h12345678);
        tick();
        chk("t3_one_cycle", {31'd0, dmem_out}, 64'd0);

        // 4: fences
        for (int i = 0; i < 3; i++) do_store(32'h300 + 32'(i * 4), 32'hB000 + 32'(i));
        issue(1'b1, 32'h0, 32'h0, 4'h0, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("t4_wait0", {63'd0, dmem_out.mem_ready}, 64'd0);
        rsp(32'd0);
        rsp(32'd0);
        chk("t4_wait2", {63'd0, dmem_out.mem_ready}, 64'd0);
        rsp(32'd0);
        wait_ready("t4_fence_ack");
        issue(1'b1, 32'h0, 32'h0, 4'h0, 32'd0);
        chk("t4_f0_c1", {63'd0, dmem_out.mem_ready}, 64'd0);
        tick();
        chk("t4_f0_c2", {63'd0, dmem_out.mem_ready}, 64'd1);
        tick();

        // 5: backpressure keeps fields stable, one handshake
        bus_req_ready = 1'b0;
        issue(1'b0, 32'h340, 32'hA5A50F0F, 4'h3, 32'd0);
        for (int i = 0; i < 7; i++) begin
            chk("t5_stable_ctl", {24'd0, bus_req_valid, bus_req_write, bus_req_wstrb, bus_req_addr},
                {24'd0, 1'b1, 1'b1, 4'h3, 32'h340});
            chk("t5_stable_wdata", {32'd0, bus_req_wdata}, 64'hA5A50F0F);
            tick();
        end
        hs0 = n_hs;
        bus_req_ready = 1'b1;
        wait_ready("t5_ack");
        chk("t5_one_hs", 64'(n_hs - hs0), 64'd1);
        rsp(32'd0);

        // 6: reset during RESP, then a stray response
        chk("t6_err_pre", {63'd0, err}, 64'd0);
        issue(1'b0, 32'h400, 32'h0, 4'h0, 32'hCAFEF00D);
        wait_req("t6_read_issued");
        tick();
        reset = 1'b0;
        #1;
        chk("t6_rst_outputs", {29'd0, bus_req_valid, dmem_out, err, bus_req_wstrb[0], bus_req_write}, 64'd0);
        void'(exp_ack.pop_back());
        tick();
        reset = 1'b1;
        tick();
        rsp(32'h55555555);
        chk("t6_err_set", {63'd0, err}, 64'd1);
        chk("t6_state_idle", {61'd0, dut.r_reg.state}, 64'd0);
        tick();

        chk("sb_req_empty", 64'(exp_req.size()), 64'd0);
        chk("sb_ack_empty", 64'(exp_ack.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
